// File: rtl/cpu_pkg.sv
// Shared CPU constants and the program-loader state encoding.
// PROGLOADER_CHECKSUM_EN adds the checksum and error states.
package cpu_pkg;

    localparam int INSTR_W         = 18;
    localparam int ADDR_W          = 16;
    localparam int BYTES_PER_INSTR = 3;

    localparam logic [3:0] LD_HDR_HI = 4'd0;
    localparam logic [3:0] LD_HDR_LO = 4'd1;
    localparam logic [3:0] LD_B0     = 4'd2;
    localparam logic [3:0] LD_B1     = 4'd3;
    localparam logic [3:0] LD_B2     = 4'd4;
    localparam logic [3:0] LD_WR     = 4'd5;
    localparam logic [3:0] LD_DONE   = 4'd6;
`ifdef PROGLOADER_CHECKSUM_EN
    localparam logic [3:0] LD_CSUM   = 4'd7;
    localparam logic [3:0] LD_ERR    = 4'd8;
`endif

    // ST_WR is the one-cycle write bubble after each B2 byte.
    typedef enum logic [3:0] {
        ST_HDR_HI = LD_HDR_HI,
        ST_HDR_LO = LD_HDR_LO,
        ST_B0     = LD_B0,
        ST_B1     = LD_B1,
        ST_B2     = LD_B2,
        ST_WR     = LD_WR,
        ST_DONE   = LD_DONE
`ifdef PROGLOADER_CHECKSUM_EN
        , ST_CSUM = LD_CSUM,
        ST_ERR    = LD_ERR
`endif
    } ld_state_e;

    function automatic logic rx_open(input ld_state_e s);
        logic open;
        open = 1'b0;
        case (s)
            ST_HDR_HI, ST_HDR_LO, ST_B0, ST_B1, ST_B2: open = 1'b1;
`ifdef PROGLOADER_CHECKSUM_EN
            ST_CSUM: open = 1'b1;
`endif
            default: open = 1'b0;
        endcase
        return open;
    endfunction

endpackage

// File: rtl/progloader_wordassembler.sv
// Collects three payload bytes into one 18-bit instruction word:
// B0[1:0] become the two top bits, then B1, then B2.
module wordassembler
    import cpu_pkg::*;
(
    input  logic               i_clock,
    input  logic               i_resetN,
    input  logic               i_clr,
    input  logic               i_byte_vld,
    input  logic [7:0]         i_byte,
    output logic [INSTR_W-1:0] o_word,
    output logic               o_word_vld
);

    logic [1:0]         idx_q, idx_d;
    logic [INSTR_W-9:0] shift_q, shift_d;

    always_comb begin
        idx_d      = idx_q;
        shift_d    = shift_q;
        o_word_vld = 1'b0;
        o_word     = {shift_q, i_byte};
        if (i_clr) begin
            idx_d   = '0;
            shift_d = '0;
        end else if (i_byte_vld) begin
            if (idx_q == 2'(BYTES_PER_INSTR - 1)) begin
                idx_d      = '0;
                o_word_vld = 1'b1;
            end else begin
                idx_d = idx_q + 2'd1;
            end
            if (idx_q == '0)
                shift_d = {8'd0, i_byte[1:0]};
            else
                shift_d = {shift_q[1:0], i_byte};
        end
    end

    always_ff @(posedge i_clock or negedge i_resetN) begin
        if (!i_resetN) begin
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/progloader.sv
// Boot-stage program loader: byte stream -> 18-bit words -> instruction memory,
// holding the CPU until done. PROGLOADER_CHECKSUM_EN enables the trailing XOR check.
module progloader #(
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W
) (
    input  logic               i_clock,
    input  logic               i_resetN,
    input  logic [7:0]         i_rxData,
    input  logic               i_rxValid,
    output logic               o_rxReady,
    input  logic               i_start,
    output logic               o_wEn,
    output logic [0:ADDR_W-1]  o_wAddr,
    output logic [0:INSTR_W-1] o_wData,
    output logic               o_cpuHold,
    output logic               o_done,
    output logic               o_error
);
    import cpu_pkg::*;

`ifdef PROGLOADER_CHECKSUM_EN
    localparam ld_state_e LOAD_END = ST_CSUM;
`else
    localparam ld_state_e LOAD_END = ST_DONE;
`endif

    ld_state_e          state_q, state_d;
    logic               rdy_q, rdy_d;
    logic               wen_q, wen_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [INSTR_W-1:0] wdata_q, wdata_d;
    logic               hold_q, hold_d;
    logic               done_q, done_d;
    logic [15:0]        count_q, count_d;
    logic               acc, restart, asm_vld, word_vld;
    logic [INSTR_W-1:0] word;
`ifdef PROGLOADER_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
    logic               err_q, err_d;
`endif

    assign acc     = i_rxValid & rdy_q;
    assign asm_vld = acc && (state_q == ST_B0 || state_q == ST_B1 || state_q == ST_B2);

    wordassembler u_asm (
        .i_clock    (i_clock),
        .i_resetN   (i_resetN),
        .i_clr      (restart),
        .i_byte_vld (asm_vld),
        .i_byte     (i_rxData),
        .o_word     (word),
        .o_word_vld (word_vld)
    );

    always_comb begin
        state_d = state_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        restart = 1'b0;
`ifdef PROGLOADER_CHECKSUM_EN
        csum_d  = (acc && state_q != ST_CSUM) ? (csum_q ^ i_rxData) : csum_q;
`endif
        case (state_q)
            ST_HDR_HI: if (acc) begin
                count_d[15:8] = i_rxData;
                state_d       = ST_HDR_LO;
            end
            // A zero count still passes through the bubble so timing matches a write.
            ST_HDR_LO: if (acc) begin
                count_d[7:0] = i_rxData;
                state_d      = ({count_q[15:8], i_rxData} == 16'd0) ? ST_WR : ST_B0;
            end
            ST_B0: if (acc) state_d = ST_B1;
            ST_B1: if (acc) state_d = ST_B2;
            ST_B2: if (acc) state_d = ST_WR;
            ST_WR: begin
                if (wen_q) waddr_d = waddr_q + ADDR_W'(1);
                state_d = (count_q == 16'd0) ? LOAD_END : ST_B0;
            end
            ST_DONE: if (i_start) restart = 1'b1;
`ifdef PROGLOADER_CHECKSUM_EN
            ST_CSUM: if (acc) state_d = (i_rxData == csum_q) ? ST_DONE : ST_ERR;
            ST_ERR:  if (i_start) restart = 1'b1;
`endif
            default: state_d = ST_HDR_HI;
        endcase

        if (word_vld) begin
            wen_d   = 1'b1;
            wdata_d = word;
            count_d = count_q - 16'd1;
        end

        if (restart) begin
            state_d = ST_HDR_HI;
            waddr_d = '0;
            count_d = '0;
`ifdef PROGLOADER_CHECKSUM_EN
            csum_d  = '0;
`endif
        end

        rdy_d  = rx_open(state_d);
        hold_d = (state_d != ST_DONE);
        done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
`ifdef PROGLOADER_CHECKSUM_EN
        err_d  = (state_d == ST_ERR);
`endif
    end

    always_ff @(posedge i_clock or negedge i_resetN) begin
        if (!i_resetN) begin
            state_q <= ST_HDR_HI;
            rdy_q   <= 1'b0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            count_q <= '0;
`ifdef PROGLOADER_CHECKSUM_EN
            csum_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            count_q <= count_d;
`ifdef PROGLOADER_CHECKSUM_EN
            csum_q  <= csum_d;
            err_q   <= err_d;
`endif
        end
    end

    assign o_rxReady = rdy_q;
    assign o_wEn     = wen_q;
    assign o_wAddr   = waddr_q;
    assign o_wData   = wdata_q;
    assign o_cpuHold = hold_q;
    assign o_done    = done_q;
`ifdef PROGLOADER_CHECKSUM_EN
    assign o_error   = err_q;
`else
    assign o_error   = 1'b0;
`endif

endmodule

// File: tb/tb_progloader.sv
// Directed, table-driven bench for progloader; honours PROGLOADER_CHECKSUM_EN.
module tb_progloader;

    logic        clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0, start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready, wen, hold, done, err;
    logic [0:15] waddr;
    logic [0:17] wdata;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    progloader dut (
        .i_clock   (clk),
        .i_resetN  (rst_n),
        .i_rxData  (rx_data),
        .i_rxValid (rx_valid),
        .o_rxReady (rx_ready),
        .i_start   (start),
        .o_wEn     (wen),
        .o_wAddr   (waddr),
        .o_wData   (wdata),
        .o_cpuHold (hold),
        .o_done    (done),
        .o_error   (err)
    );

    typedef struct packed {
        logic        rdy;
        logic        wen;
        logic [15:0] addr;
        logic [17:0] data;
        logic        hold;
        logic        done;
        logic        err;
    } obs_t;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       st;
        obs_t       exp;
    } vec_t;

    vec_t vq[$];

    function automatic obs_t ob(logic rdy, logic we, logic [15:0] a, logic [17:0] dt,
                                logic hd, logic dn_, logic er);
        obs_t r;
        r.rdy = rdy; r.wen = we; r.addr = a; r.data = dt;
        r.hold = hd; r.done = dn_; r.err = er;
        return r;
    endfunction

    function automatic obs_t busy(logic [15:0] a, logic [17:0] dt); return ob(1, 0, a, dt, 1, 0, 0); endfunction
    function automatic obs_t wr(logic [15:0] a, logic [17:0] dt);   return ob(0, 1, a, dt, 1, 0, 0); endfunction
    function automatic obs_t bub(logic [15:0] a, logic [17:0] dt);  return ob(0, 0, a, dt, 1, 0, 0); endfunction
    function automatic obs_t dn(logic [15:0] a, logic [17:0] dt, logic p); return ob(0, 0, a, dt, 0, p, 0); endfunction

    function automatic obs_t cur();
        return ob(rx_ready, wen, waddr, wdata, hold, done, err);
    endfunction

    function automatic void add(logic v, logic [7:0] d, logic st, obs_t e);
        vec_t x;
        x.v = v; x.d = d; x.st = st; x.exp = e;
        vq.push_back(x);
    endfunction

    // Rows following a load's write bubble: optional checksum byte, then the DONE pulse.
    function automatic void add_tail(logic [15:0] a, logic [17:0] dt, logic [7:0] cs,
                                     logic v, logic [7:0] d);
`ifdef PROGLOADER_CHECKSUM_EN
        add(v, d, 0, busy(a, dt));
        add(1, cs, 0, dn(a, dt, 1));
`else
        add(v, d, 0, dn(a, dt, 1));
`endif
        add(0, 8'h00, 0, dn(a, dt, 0));
    endfunction

    task automatic chk(string nm, obs_t got, obs_t exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got rdy=%b wen=%b addr=%h data=%h hold=%b done=%b err=%b, want rdy=%b wen=%b addr=%h data=%h hold=%b done=%b err=%b",
                     nm, got.rdy, got.wen, got.addr, got.data, got.hold, got.done, got.err,
                     exp.rdy, exp.wen, exp.addr, exp.data, exp.hold, exp.done, exp.err);
        end
    endtask

    task automatic step(logic v, logic [7:0] d, logic st);
        @(negedge clk);
        rx_valid = v; rx_data = d; start = st;
        @(posedge clk);
        #1;
    endtask

    task automatic finish_load(string nm, logic [15:0] a, logic [17:0] dt, logic [7:0] cs);
        step(0, 8'h00, 0);
`ifdef PROGLOADER_CHECKSUM_EN
        chk({nm, "_csum_state"}, cur(), busy(a, dt));
        step(1, cs, 0);
`endif
        chk({nm, "_done_pulse"}, cur(), dn(a, dt, 1));
        step(0, 8'h00, 0);
        chk({nm, "_done_level"}, cur(), dn(a, dt, 0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Count=1, payload 03 AB CD; a valid byte offered in the bubble is not taken.
        add(1, 8'h00, 0, busy(0, 0));
        add(1, 8'h01, 0, busy(0, 0));
        add(1, 8'h03, 0, busy(0, 0));
        add(1, 8'hAB, 0, busy(0, 0));
        add(1, 8'hCD, 0, wr(0, 18'h3ABCD));
        add_tail(1, 18'h3ABCD, 8'h64, 1, 8'hEE);
        // Restart, count=0: bubble then DONE with no write.
        add(0, 8'h00, 1, busy(0, 18'h3ABCD));
        add(1, 8'h00, 0, busy(0, 18'h3ABCD));
        add(1, 8'h00, 0, bub(0, 18'h3ABCD));
        add_tail(0, 18'h3ABCD, 8'h00, 0, 8'h00);
        // Restart, count=3 with valid toggling every other cycle.
        add(0, 8'h00, 1, busy(0, 18'h3ABCD));
        add(1, 8'h00, 0, busy(0, 18'h3ABCD));
        add(0, 8'hFF, 0, busy(0, 18'h3ABCD));
        add(1, 8'h03, 0, busy(0, 18'h3ABCD));
        add(0, 8'hFF, 0, busy(0, 18'h3ABCD));
        add(1, 8'h01, 0, busy(0, 18'h3ABCD));
        add(0, 8'hFF, 0, busy(0, 18'h3ABCD));
        add(1, 8'h12, 0, busy(0, 18'h3ABCD));
        add(0, 8'hFF, 0, busy(0, 18'h3ABCD));
        add(1, 8'h34, 0, wr(0, 18'h11234));
        add(0, 8'hFF, 0, busy(1, 18'h11234));
        add(1, 8'hFE, 0, busy(1, 18'h11234));
        add(0, 8'hFF, 0, busy(1, 18'h11234));
        add(1, 8'h56, 0, busy(1, 18'h11234));
        add(0, 8'hFF, 0, busy(1, 18'h11234));
        add(1, 8'h78, 0, wr(1, 18'h25678));
        add(0, 8'hFF, 0, busy(2, 18'h25678));
        add(1, 8'h07, 0, busy(2, 18'h25678));
        add(0, 8'hFF, 0, busy(2, 18'h25678));
        add(1, 8'h9A, 0, busy(2, 18'h25678));
        add(0, 8'hFF, 0, busy(2, 18'h25678));
        add(1, 8'hBC, 0, wr(2, 18'h39ABC));
        add_tail(3, 18'h39ABC, 8'hD5, 0, 8'hFF);

        #12;
        chk("reset_state", cur(), ob(0, 0, 0, 0, 1, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 8'h00, 0);
        chk("rdy_after_release", cur(), busy(0, 0));

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].v, vq[i].d, vq[i].st);
            chk($sformatf("vec%0d", i), cur(), vq[i].exp);
        end

        // Reset asserted mid-load after the B1 byte of word 2, then reload.
        step(0, 8'h00, 1);
        chk("mid_restart", cur(), busy(0, 18'h39ABC));
        step(1, 8'h00, 0);
        step(1, 8'h03, 0);
        step(1, 8'h01, 0);
        step(1, 8'h12, 0);
        step(1, 8'h34, 0);
        chk("mid_word1", cur(), wr(0, 18'h11234));
        step(0, 8'h00, 0);
        step(1, 8'hFE, 0);
        step(1, 8'h56, 0);
        chk("mid_b1_w2", cur(), busy(1, 18'h11234));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", cur(), ob(0, 0, 0, 0, 1, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 8'h00, 0);
        chk("post_reset_rdy", cur(), busy(0, 0));
        step(1, 8'h00, 0);
        step(1, 8'h01, 0);
        step(1, 8'h03, 0);
        step(1, 8'hAB, 0);
        step(1, 8'hCD, 0);
        chk("reload_addr0", cur(), wr(0, 18'h3ABCD));
        finish_load("reload", 1, 18'h3ABCD, 8'h64);

        // i_start during B1 is ignored.
        step(0, 8'h00, 1);
        chk("s2_restart", cur(), busy(0, 18'h3ABCD));
        step(1, 8'h00, 0);
        step(1, 8'h01, 0);
        step(1, 8'h02, 0);
        step(1, 8'h55, 1);
        chk("start_ignored", cur(), busy(0, 18'h3ABCD));
        step(1, 8'h66, 0);
        chk("s2_write", cur(), wr(0, 18'h25566));
        finish_load("s2", 1, 18'h25566, 8'h30);

`ifdef PROGLOADER_CHECKSUM_EN
        // Good checksum, then bad checksum into ERR, then restart out of ERR.
        for (int k = 0; k < 2; k++) begin
            step(0, 8'h00, 1);
            step(1, 8'h00, 0);
            step(1, 8'h01, 0);
            step(1, 8'h01, 0);
            step(1, 8'h02, 0);
            step(1, 8'h03, 0);
            chk($sformatf("cs%0d_write", k), cur(), wr(0, 18'h10203));
            step(0, 8'h00, 0);
            chk($sformatf("cs%0d_state", k), cur(), busy(1, 18'h10203));
            if (k == 0) begin
                step(1, 8'h01, 0);
                chk("csum_good_done", cur(), dn(1, 18'h10203, 1));
            end else begin
                step(1, 8'h00, 0);
                chk("csum_bad_err", cur(), ob(0, 0, 1, 18'h10203, 1, 0, 1));
                step(1, 8'h01, 0);
                chk("err_holds", cur(), ob(0, 0, 1, 18'h10203, 1, 0, 1));
            end
        end
        step(0, 8'h00, 1);
        chk("restart_from_err", cur(), busy(0, 18'h10203));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/progloader.md
# progloader

Upstream boot stage for the 16-bit CPU. It receives a program as a byte stream over a valid/ready handshake and assembles each group of three bytes into an 18-bit instruction word. It writes the words sequentially into the instruction memory that feeds the program ROM port, and holds the CPU core in halt until the load completes.

## Interface
Parameters:
- ADDR_W, 16: instruction-address width; matches the CPU instruction pointer.
- INSTR_W, 18: instruction width; fixed by the control unit.

Ports:
- i_clock  in  1  single system clock; all state is rising-edge.
- i_resetN  in  1  asynchronous, active-low reset.
- i_rxData  in  8  incoming byte.
- i_rxValid  in  1  i_rxData is valid this cycle.
- o_rxReady  out  1  loader accepts a byte this cycle. A handshake completes when i_rxValid and o_rxReady are both high.
- i_start  in  1  restart request, honoured only in DONE or ERR.
- o_wEn  out  1  instruction-memory write strobe, one cycle wide.
- o_wAddr  out  ADDR_W  write address, MSB at index 0.
- o_wData  out  INSTR_W  write data, indexed [0:17] with MSB at index 0.
- o_cpuHold  out  1  holds the CPU (IP and register writes frozen) while high.
- o_done  out  1  one-cycle pulse when the load has completed successfully.
- o_error  out  1  level signal, high while in ERR.

## Operation
- States: HDR_HI, HDR_LO, B0, B1, B2, CSUM (only with the macro), DONE, ERR.
- Reset values:
  - State is HDR_HI.
  - o_rxReady=0 while reset is asserted; it becomes 1 in the first cycle after release.
  - o_wEn=0, o_wAddr=0, o_wData=0, o_cpuHold=1, o_done=0, o_error=0.
  - Internal count=0 and checksum=0.
- Header:
  - HDR_HI takes count[15:8].
  - HDR_LO takes count[7:0].
  - Count is an unsigned word count from 0 to 65535.
  - If count==0, go to CSUM (macro on) or DONE (macro off). Otherwise go to B0.
- Payload, per word:
  - B0 byte bits [1:0] become instr[0:1]; bits [7:2] are ignored.
  - B1 byte becomes instr[2:9].
  - B2 byte becomes instr[10:17].
  - Accepting the B2 byte registers the word. In the next cycle o_wEn=1 with o_wData set to the word and o_wAddr set to the current address.
  - The address increments after the write and the remaining count decrements.
  - If the count is still nonzero, go to B0. Otherwise go to CSUM or DONE.
- o_rxReady=1 in HDR_HI, HDR_LO, B0, B1, B2 and CSUM. It is 0 in DONE and ERR, and 0 in the write cycle after B2 (one bubble per word).
- DONE:
  - o_cpuHold=0.
  - o_done pulses in the first DONE cycle only.
  - o_wData holds its last value.
- Restart: i_start in DONE or ERR returns the loader to HDR_HI. o_wAddr and the checksum are cleared and o_cpuHold is set, all in the next cycle. i_start in any other state is ignored.
- Address wrap: a count of 65535 writes addresses 0 to 65534. The address register wraps modulo 2^16, but no load can reach that wrap.
- Reset mid-load: all outputs return to their reset values. Words already written are not cleared.
- Stall: the loader waits indefinitely for i_rxValid. There is no timeout.

## Timing
- Each byte handshake takes one cycle. A full word costs 4 cycles at minimum: 3 bytes plus 1 write bubble.
- Latency from the B2 handshake to o_wEn is 1 cycle.
- Last word, macro off: the last B2 handshake is in cycle t, o_wEn is high in t+1, and DONE is entered in t+2. In DONE, o_cpuHold falls and o_done pulses.
- Last word, macro on: CSUM is entered in t+2. If the checksum byte is accepted in cycle c, DONE or ERR is entered in c+1.
- All outputs are registered. There are no combinational paths from inputs to outputs except that o_rxReady depends on state only.

## Configuration
- PROGLOADER_CHECKSUM_EN defined:
  - The loader keeps a running XOR of all header and payload bytes.
  - The CSUM state accepts one further byte.
  - On a match, go to DONE.
  - On a mismatch, go to ERR: o_error=1 and o_cpuHold stays at 1.
- PROGLOADER_CHECKSUM_EN undefined: the CSUM state, the checksum register and the ERR state do not exist, and o_error is tied to 0.

## Structure
- Shared package cpu_pkg holds:
  - INSTR_W=18 and ADDR_W=16;
  - the loader state encoding as localparams;
  - BYTES_PER_INSTR=3.
- One sub-module, wordassembler, gathers three bytes into an 18-bit word using a byte index plus a shift register. The FSM, counters and checksum stay in progloader.

## Test plan
- Count=1 (header bytes 0x00 0x01), payload 0x03 0xAB 0xCD → one o_wEn at addr 0, data 18'h3ABCD. o_done pulses 2 cycles after the last byte and o_cpuHold falls in the same cycle.
- Count=0 with the macro off → DONE two cycles after HDR_LO is accepted, with no o_wEn.
- Count=3 with i_rxValid toggling every other cycle → writes at addresses 0, 1, 2, each in the cycle after its B2 byte. o_rxReady is low in each write cycle.
- Macro on, count=1, payload 0x01 0x02 0x03:
  - checksum byte 0x01 → DONE;
  - checksum byte 0x00 → ERR with o_error=1 and o_cpuHold=1;
  - then i_start → HDR_HI with o_wAddr=0.
- i_resetN asserted after the B1 byte of word 2 → outputs take their reset values asynchronously. A reload after release starts at address 0.
- i_start pulsed during B1 → ignored, and the load completes normally.
